tcp_sched_flag_table: RTL and testbench
=======================================

Name: tcp_sched_flag_table

Overview:
- Per-flow scheduler flag store that consumes sched_cmd_struct commands from the TCP engines (RX/ack path, app send path, RT timer).
- Holds an rt / ack_pend / data_pend flag plus a timestamp per flow.
- A round-robin scanner emits sched_data_struct records for eligible flows to the downstream send-packet builder.
- Sits directly between the command producers and the send_pkt_struct generation stage.

Parameters:
- NUM_FLOWS, 64, number of table entries; power of 2, at most 2**FLOWID_W.
- FLOWID_W, TIMESTAMP_W, SCHED_CMD_STRUCT_W, SCHED_DATA_STRUCT_W: taken from tcp_pkg / tcp_misc_pkg, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- sched_cmd_val  in  1  command valid.
- sched_cmd_data  in  SCHED_CMD_STRUCT_W  sched_cmd_struct.
- sched_cmd_rdy  out  1  command accepted.
- cur_time  in  TIMESTAMP_W  free-running time, for rt eligibility.
- sched_data_val  out  1  emitted record valid.
- sched_data  out  SCHED_DATA_STRUCT_W  sched_data_struct for one flow.
- sched_data_rdy  in  1  downstream accept.

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset state:
  - Every entry: all flags 0, all timestamps 0.
  - scan_idx = 0, FSM = SCAN.
  - sched_data_val = 0, sched_data = 0.
  - sched_cmd_rdy = 1 from the first cycle after reset.
- Storage: flop array, one sched_data_struct-minus-flowid per entry, so a read and a write can happen in the same cycle.
- Commands:
  - sched_cmd_rdy is tied to 1 outside reset; one command is accepted per cycle on val.
  - Decoding is per flag field:
    - SET: flag <= 1, timestamp <= cmd timestamp.
    - CLEAR: flag <= 0, timestamp <= 0.
    - NOP: unchanged.
    - Encoding 2'd3: treated as NOP.
  - flowid >= NUM_FLOWS: command dropped and entry untouched; the command is still accepted.
  - Write latency: the scanner sees the update the cycle after acceptance.
- Eligibility of entry e:
  - ack_elig = ack_pend_flag.
  - data_elig = data_pend_flag.
  - rt_elig = rt_flag AND (cur_time - rt_ts) has MSB 0. The subtraction is TIMESTAMP_W-bit modular, so it is wrap-safe over half the timestamp range.
  - Entry eligible = any of the three.
- FSM SCAN:
  - Examine entry[scan_idx] each cycle.
  - Not eligible: scan_idx <= scan_idx+1, wrapping modulo NUM_FLOWS.
  - Eligible: register sched_data, clear the captured flags in the table, go to HOLD.
    - sched_data contents: flowid = scan_idx; each flag field = its elig bit; each timestamp = the stored timestamp.
    - Only flags reported as 1 are cleared; non-eligible flags, including a set-but-not-due rt, stay.
- FSM HOLD:
  - sched_data_val = 1; sched_data held stable.
  - On sched_data_rdy: scan_idx+1, val drops next cycle, return to SCAN.
  - Eligible→val latency is 1 cycle.
  - Maximum emission rate is one per 2 cycles.
- Simultaneous command and capture on the same flow, same cycle, per flag:
  - A SET or CLEAR command result wins.
  - Else, if the flag was captured, it is cleared.
  - Else it is unchanged.
  - The emitted snapshot reflects the pre-command value.
- Commands continue to be accepted during HOLD, including to the held flow; the held record is not modified.
- Reset asserted mid-HOLD: val = 0 on the next cycle and the record is lost.
- Empty table: the scanner walks continuously and val stays 0.

Optional Feature:
- Macro: TCP_SCHED_FLAG_TABLE_STATS_EN.
- When defined, adds three outputs:
  - stat_cmd_cnt (32b): accepted in-range commands.
  - stat_emit_cnt (32b): sched_data handshakes.
  - stat_drop_cnt (16b): out-of-range commands.
- All counters reset to 0 and saturate at all-ones.
- When not defined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then SET ack on flow 5 at cycle 0 → sched_data_val rises by cycle 7 with flowid 5, ack flag 1, rt/data 0; after rdy, entry 5 ack reads 0 and no re-emission.
- SET rt on flow 3 with ts=100, cur_time=90 → no emission while cur_time < 100. Step cur_time to 100 → emission with rt=1, ts=100. Repeat with ts=0x0002 and cur_time=0xFFFE (wrap) → no emission until cur_time reaches 2.
- SET data on flows 1, 2, 63 with rdy held 0 for 10 cycles → flow 1 held stable; after releasing rdy, emissions come in order 1, 2, 63 and the scan wraps to 0.
- In the capture cycle for flow 4 (ack set), drive SET data on flow 4 → emitted ack=1, data=0; the table then holds ack=0, data=1, and flow 4 emits again on the next pass.
- Command with flowid 64 for NUM_FLOWS=64 → dropped, rdy=1, no emission; with the STATS macro on, stat_drop_cnt=1 and stat_cmd_cnt=0.
- Assert rst during HOLD on flow 9 → val=0 the next cycle; after reset no entry emits.

Source files
------------

// File: rtl/tcp_sched_flag_table.sv
// Per-flow scheduler flag store (rt / ack_pend / data_pend) with a round-robin emitter.
// Optional statistics counters are enabled by defining TCP_SCHED_FLAG_TABLE_STATS_EN.

package tcp_pkg;
  localparam int FLOWID_W    = 8;
  localparam int TIMESTAMP_W = 16;

  localparam logic [1:0] SCHED_NOP = 2'd0;
  localparam logic [1:0] SCHED_SET = 2'd1;
  localparam logic [1:0] SCHED_CLR = 2'd2;

  typedef struct packed {
    logic [FLOWID_W-1:0]    flowid;
    logic [1:0]             rt_cmd;
    logic [1:0]             ack_cmd;
    logic [1:0]             data_cmd;
    logic [TIMESTAMP_W-1:0] ts;
  } sched_cmd_struct;

  typedef struct packed {
    logic                   rt;
    logic [TIMESTAMP_W-1:0] rt_ts;
    logic                   ack;
    logic [TIMESTAMP_W-1:0] ack_ts;
    logic                   data;
    logic [TIMESTAMP_W-1:0] data_ts;
  } sched_entry_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    sched_entry_struct   ent;
  } sched_data_struct;

  localparam int SCHED_CMD_STRUCT_W  = $bits(sched_cmd_struct);
  localparam int SCHED_DATA_STRUCT_W = $bits(sched_data_struct);
endpackage

module tcp_sched_flag_table
  import tcp_pkg::*;
#(
  parameter int NUM_FLOWS = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sched_cmd_val,
  input  logic [SCHED_CMD_STRUCT_W-1:0]  sched_cmd_data,
  output logic                           sched_cmd_rdy,
  input  logic [TIMESTAMP_W-1:0]         cur_time,
  output logic                           sched_data_val,
  output logic [SCHED_DATA_STRUCT_W-1:0] sched_data,
  input  logic                           sched_data_rdy
`ifdef TCP_SCHED_FLAG_TABLE_STATS_EN
  ,
  output logic [31:0]                    stat_cmd_cnt,
  output logic [31:0]                    stat_emit_cnt,
  output logic [15:0]                    stat_drop_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_FLOWS);
  localparam logic [FLOWID_W:0] NUM_FLOWS_L = (FLOWID_W+1)'(NUM_FLOWS);

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // {write_enable, flag, timestamp}; NOP and the reserved encoding never write.
  function automatic logic [TIMESTAMP_W+1:0] field_upd(input logic [1:0] op,
                                                       input logic [TIMESTAMP_W-1:0] ts);
    case (op)
      SCHED_SET: field_upd = {1'b1, 1'b1, ts};
      SCHED_CLR: field_upd = {1'b1, 1'b0, {TIMESTAMP_W{1'b0}}};
      default:   field_upd = {1'b0, 1'b0, {TIMESTAMP_W{1'b0}}};
    endcase
  endfunction

  sched_entry_struct          table_r [NUM_FLOWS];
  state_t                     state_r, state_s;
  logic [IDX_W-1:0]           scan_idx_r, scan_idx_s;
  sched_data_struct           data_r, data_s;
  logic                       val_r, val_s, rdy_r, capture_s;
  sched_cmd_struct            cmd_s;
  sched_entry_struct          cur_s, snap_s;
  logic [TIMESTAMP_W-1:0]     rt_age_s;
  logic                       cmd_in_range_s, cmd_hit_s, elig_any_s;
  logic [IDX_W-1:0]           cmd_idx_s;
  logic [TIMESTAMP_W+1:0]     rt_upd_s, ack_upd_s, data_upd_s;

  assign cmd_s          = sched_cmd_struct'(sched_cmd_data);
  assign cmd_in_range_s = ({1'b0, cmd_s.flowid} < NUM_FLOWS_L);
  assign cmd_hit_s      = sched_cmd_val && cmd_in_range_s;
  assign cmd_idx_s      = cmd_s.flowid[IDX_W-1:0];
  assign rt_upd_s       = field_upd(cmd_s.rt_cmd, cmd_s.ts);
  assign ack_upd_s      = field_upd(cmd_s.ack_cmd, cmd_s.ts);
  assign data_upd_s     = field_upd(cmd_s.data_cmd, cmd_s.ts);

  assign cur_s    = table_r[scan_idx_r];
  assign rt_age_s = cur_time - cur_s.rt_ts;

  // Eligibility snapshot of the scanned entry; rt is due once the modular age is non-negative.
  always_comb begin
    snap_s     = cur_s;
    snap_s.rt  = cur_s.rt && !rt_age_s[TIMESTAMP_W-1];
    elig_any_s = snap_s.rt || snap_s.ack || snap_s.data;
  end

  // Scanner next-state, capture decision and output record.
  always_comb begin
    state_s    = state_r;
    scan_idx_s = scan_idx_r;
    data_s     = data_r;
    val_s      = val_r;
    capture_s  = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (elig_any_s) begin
          capture_s     = 1'b1;
          data_s.flowid = FLOWID_W'(scan_idx_r);
          data_s.ent    = snap_s;
          val_s         = 1'b1;
          state_s       = ST_HOLD;
        end else begin
          scan_idx_s = scan_idx_r + 1'b1;
        end
      end
      ST_HOLD: begin
        if (sched_data_rdy) begin
          scan_idx_s = scan_idx_r + 1'b1;
          val_s      = 1'b0;
          state_s    = ST_SCAN;
        end else begin
          val_s = 1'b1;
        end
      end
      default: begin
        val_s   = 1'b0;
        state_s = ST_SCAN;
      end
    endcase
  end

  // Scanner state and registered output record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_SCAN;
      scan_idx_r <= '0;
      data_r     <= '0;
      val_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      scan_idx_r <= scan_idx_s;
      data_r     <= data_s;
      val_r      <= val_s;
    end
  end

  // The command port never back-pressures.
  always_ff @(posedge clk) begin
    rdy_r <= 1'b1;
  end

  // Flag table: capture clears reported flags; a later SET/CLEAR to the same field overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_FLOWS; e++) begin
        table_r[e] <= '0;
      end
    end else begin
      if (capture_s) begin
        if (snap_s.rt)   table_r[scan_idx_r].rt   <= 1'b0;
        if (snap_s.ack)  table_r[scan_idx_r].ack  <= 1'b0;
        if (snap_s.data) table_r[scan_idx_r].data <= 1'b0;
      end
      if (cmd_hit_s && rt_upd_s[TIMESTAMP_W+1]) begin
        {table_r[cmd_idx_s].rt, table_r[cmd_idx_s].rt_ts} <= rt_upd_s[TIMESTAMP_W:0];
      end
      if (cmd_hit_s && ack_upd_s[TIMESTAMP_W+1]) begin
        {table_r[cmd_idx_s].ack, table_r[cmd_idx_s].ack_ts} <= ack_upd_s[TIMESTAMP_W:0];
      end
      if (cmd_hit_s && data_upd_s[TIMESTAMP_W+1]) begin
        {table_r[cmd_idx_s].data, table_r[cmd_idx_s].data_ts} <= data_upd_s[TIMESTAMP_W:0];
      end
    end
  end

  assign sched_cmd_rdy  = rdy_r;
  assign sched_data_val = val_r;
  assign sched_data     = data_r;

`ifdef TCP_SCHED_FLAG_TABLE_STATS_EN
  logic [31:0] cmd_cnt_r, emit_cnt_r;
  logic [15:0] drop_cnt_r;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt_r  <= 32'd0;
      emit_cnt_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (cmd_hit_s && (cmd_cnt_r != 32'hFFFF_FFFF)) cmd_cnt_r <= cmd_cnt_r + 32'd1;
      if (val_r && sched_data_rdy && (emit_cnt_r != 32'hFFFF_FFFF)) emit_cnt_r <= emit_cnt_r + 32'd1;
      if (sched_cmd_val && !cmd_in_range_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign stat_cmd_cnt  = cmd_cnt_r;
  assign stat_emit_cnt = emit_cnt_r;
  assign stat_drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_tcp_sched_flag_table.sv
// Scoreboard bench for tcp_sched_flag_table: directed scenarios plus randomized traffic
// checked against a flow-level reference model.
module tb_tcp_sched_flag_table;
  import tcp_pkg::*;

  localparam int NF = 64;

  logic                           clk = 1'b0;
  logic                           rst = 1'b1;
  logic                           sched_cmd_val = 1'b0;
  logic [SCHED_CMD_STRUCT_W-1:0]  sched_cmd_data = '0;
  logic                           sched_cmd_rdy;
  logic [TIMESTAMP_W-1:0]         cur_time = '0;
  logic                           sched_data_val;
  logic [SCHED_DATA_STRUCT_W-1:0] sched_data;
  logic                           sched_data_rdy = 1'b1;
`ifdef TCP_SCHED_FLAG_TABLE_STATS_EN
  logic [31:0] stat_cmd_cnt, stat_emit_cnt;
  logic [15:0] stat_drop_cnt;
`endif

  tcp_sched_flag_table #(.NUM_FLOWS(NF)) dut (
    .clk(clk), .rst(rst),
    .sched_cmd_val(sched_cmd_val), .sched_cmd_data(sched_cmd_data), .sched_cmd_rdy(sched_cmd_rdy),
    .cur_time(cur_time),
    .sched_data_val(sched_data_val), .sched_data(sched_data), .sched_data_rdy(sched_data_rdy)
`ifdef TCP_SCHED_FLAG_TABLE_STATS_EN
    , .stat_cmd_cnt(stat_cmd_cnt), .stat_emit_cnt(stat_emit_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Driven command fields, mirrored for the reference model.
  int              drv_flow;
  logic [1:0]      drv_rt, drv_ack, drv_data;
  logic [15:0]     drv_ts;

  // Reference model: flag/timestamp arrays, scan pointer, hold state.
  bit              m_rt [NF], m_ack [NF], m_data [NF];
  logic [15:0]     m_rt_ts [NF], m_ack_ts [NF], m_data_ts [NF];
  int              m_ptr = 0;
  bit              m_hold = 0;
  int              m_cmd = 0, m_drop = 0, m_emit = 0, tot_emit = 0, mon_hs = 0;
  logic [SCHED_DATA_STRUCT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SCHED_DATA_STRUCT_W-1:0] mk_rec(input int f, input bit r, input logic [15:0] rts,
      input bit a, input logic [15:0] ats, input bit d, input logic [15:0] dts);
    logic [7:0] fl;
    fl = 8'(f);
    return {fl, r, rts, a, ats, d, dts};
  endfunction

  function automatic bit rt_due(input logic [15:0] now, input logic [15:0] ts);
    logic [15:0] age;
    age = now - ts;
    return age < 16'd32768;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int flow, input logic [1:0] rc, input logic [1:0] ac, input logic [1:0] dc,
                      input logic [15:0] ts);
    logic [7:0] fl;
    fl = 8'(flow);
    drv_flow = flow; drv_rt = rc; drv_ack = ac; drv_data = dc; drv_ts = ts;
    sched_cmd_data = {fl, rc, ac, dc, ts};
    sched_cmd_val = 1'b1;
    tick();
    sched_cmd_val = 1'b0;
  endtask

  // Reference model, advanced once per clock edge from the inputs the DUT sees.
  initial begin : model
    bit r, a, d;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int e = 0; e < NF; e++) begin
          m_rt[e] = 0; m_ack[e] = 0; m_data[e] = 0;
          m_rt_ts[e] = '0; m_ack_ts[e] = '0; m_data_ts[e] = '0;
        end
        m_ptr = 0; m_hold = 0; m_cmd = 0; m_drop = 0; m_emit = 0;
        exp_q.delete();
      end else begin
        if (m_hold) begin
          if (sched_data_rdy) begin
            m_ptr = (m_ptr + 1) % NF; m_hold = 0; m_emit++; tot_emit++;
          end
        end else begin
          r = m_rt[m_ptr] && rt_due(cur_time, m_rt_ts[m_ptr]);
          a = m_ack[m_ptr];
          d = m_data[m_ptr];
          if (r || a || d) begin
            exp_q.push_back(mk_rec(m_ptr, r, m_rt_ts[m_ptr], a, m_ack_ts[m_ptr], d, m_data_ts[m_ptr]));
            if (r) m_rt[m_ptr] = 0;
            if (a) m_ack[m_ptr] = 0;
            if (d) m_data[m_ptr] = 0;
            m_hold = 1;
          end else begin
            m_ptr = (m_ptr + 1) % NF;
          end
        end
        if (sched_cmd_val) begin
          if (drv_flow < NF) begin
            m_cmd++;
            if (drv_rt == 2'd1) begin m_rt[drv_flow] = 1; m_rt_ts[drv_flow] = drv_ts; end
            else if (drv_rt == 2'd2) begin m_rt[drv_flow] = 0; m_rt_ts[drv_flow] = '0; end
            if (drv_ack == 2'd1) begin m_ack[drv_flow] = 1; m_ack_ts[drv_flow] = drv_ts; end
            else if (drv_ack == 2'd2) begin m_ack[drv_flow] = 0; m_ack_ts[drv_flow] = '0; end
            if (drv_data == 2'd1) begin m_data[drv_flow] = 1; m_data_ts[drv_flow] = drv_ts; end
            else if (drv_data == 2'd2) begin m_data[drv_flow] = 0; m_data_ts[drv_flow] = '0; end
          end else begin
            m_drop++;
          end
        end
      end
    end
  end

  // Monitor: pops an expected record whenever the DUT presents a new one.
  bit have_rec = 0;
  bit rec_known = 0;
  logic [SCHED_DATA_STRUCT_W-1:0] cur_exp;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sched_data_val) begin
        if (!have_rec) begin
          have_rec = 1;
          if (exp_q.size() == 0) begin
            checks++; errors++; rec_known = 0;
            $display("FAIL unexpected_emit: got %h expected no record", sched_data);
          end else begin
            cur_exp = exp_q.pop_front(); rec_known = 1;
            chk("emit_record", 64'(sched_data), 64'(cur_exp));
          end
        end else if (rec_known) begin
          chk("hold_stable", 64'(sched_data), 64'(cur_exp));
        end
        if (sched_data_rdy && !rst) begin
          have_rec = 0; mon_hs++;
        end
      end else if (have_rec) begin
        chk("val_dropped_early", 64'(sched_data_val), 64'd1);
        have_rec = 0;
      end
      if (rst) have_rec = 0;
    end
  end

  initial begin : stim
    bit found;
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("reset_val", 64'(sched_data_val), 64'd0);
    chk("reset_data", 64'(sched_data), 64'd0);
    chk("reset_cmd_rdy", 64'(sched_cmd_rdy), 64'd1);
    tick();
    rst = 1'b0;

    // SET ack on flow 5: record within a few cycles, then no re-emission
    send(5, 2'd0, 2'd1, 2'd0, 16'h0011);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (sched_data_val) found = 1;
    end
    chk("ack5_latency", 64'(found), 64'd1);
    tick();
    repeat (140) tick();

    // rt not due until cur_time reaches ts, including across the wrap
    cur_time = 16'd90;
    send(3, 2'd1, 2'd0, 2'd0, 16'd100);
    repeat (150) tick();
    cur_time = 16'd100;
    repeat (80) tick();
    cur_time = 16'hFFFE;
    send(3, 2'd1, 2'd0, 2'd0, 16'h0002);
    repeat (150) tick();
    cur_time = 16'h0000; repeat (70) tick();
    cur_time = 16'h0001; repeat (70) tick();
    cur_time = 16'h0002; repeat (80) tick();

    // Back-pressure: data on 1, 2, 63 with rdy low, then release
    sched_data_rdy = 1'b0;
    send(1, 2'd0, 2'd0, 2'd1, 16'h0101);
    send(2, 2'd0, 2'd0, 2'd1, 16'h0202);
    send(63, 2'd0, 2'd0, 2'd1, 16'h3F3F);
    repeat (80) tick();
    sched_data_rdy = 1'b1;
    repeat (150) tick();

    // Command on flow 4 in the very cycle flow 4 is captured
    send(4, 2'd0, 2'd1, 2'd0, 16'h0404);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!m_hold && m_ptr == 4 && m_ack[4]) begin
        send(4, 2'd0, 2'd0, 2'd1, 16'h0444);
        found = 1;
      end else begin
        tick();
      end
    end
    chk("flow4_capture_cycle_hit", 64'(found), 64'd1);
    repeat (150) tick();

    // Out-of-range flowid is accepted but dropped
    chk("oor_cmd_rdy", 64'(sched_cmd_rdy), 64'd1);
    send(64, 2'd1, 2'd1, 2'd1, 16'h0000);
    repeat (100) tick();
`ifdef TCP_SCHED_FLAG_TABLE_STATS_EN
    chk("stat_drop_cnt", 64'(stat_drop_cnt), 64'(m_drop));
    chk("stat_cmd_cnt", 64'(stat_cmd_cnt), 64'(m_cmd));
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      sched_data_rdy = ($urandom_range(0, 9) < 7);
      cur_time = cur_time + 16'($urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        send($urandom_range(0, 71), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), cur_time + 16'($urandom_range(0, 40)) - 16'd20);
      end else begin
        tick();
      end
    end
    sched_data_rdy = 1'b1;
    repeat (300) tick();
`ifdef TCP_SCHED_FLAG_TABLE_STATS_EN
    chk("stat_cmd_cnt_rand", 64'(stat_cmd_cnt), 64'(m_cmd));
    chk("stat_drop_cnt_rand", 64'(stat_drop_cnt), 64'(m_drop));
    chk("stat_emit_cnt_rand", 64'(stat_emit_cnt), 64'(m_emit));
`endif

    // Reset while holding flow 9: record lost, table empty afterwards
    cur_time = cur_time + 16'd1000;
    repeat (100) tick();
    sched_data_rdy = 1'b0;
    send(9, 2'd0, 2'd1, 2'd0, 16'h0909);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (sched_data_val && sched_data[58:51] == 8'd9) found = 1;
    end
    chk("flow9_hold_reached", 64'(found), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("val_after_rst_in_hold", 64'(sched_data_val), 64'd0);
    rst = 1'b0;
    sched_data_rdy = 1'b1;
    repeat (150) tick();
    chk("no_emit_after_reset", 64'(sched_data_val), 64'd0);

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("handshake_count", 64'(mon_hs), 64'(tot_emit));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
